// File: rtl/layer_out_serializer.sv
// Gathers NN parallel neuron results into a buffer, then replays them one word per cycle.
// Optional running argmax over the emitted stream: define LAYER_SER_MAXFIND_EN.
module layer_out_serializer #(
    parameter int unsigned NN        = 30,
    parameter int unsigned dataWidth = 16,
    parameter int unsigned idxWidth  = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NN-1:0]           in_valid,
    input  logic [NN*dataWidth-1:0] in_data,
    output logic                    data_out_valid,
    output logic [dataWidth-1:0]    data_out,
    output logic                    busy,
    output logic                    overrun
`ifdef LAYER_SER_MAXFIND_EN
    ,
    output logic                    max_valid,
    output logic [idxWidth-1:0]     max_idx
`endif
);
    // One extra bit so the index can reach NN even when NN == 2**idxWidth.
    localparam int unsigned CW = idxWidth + 1;

    localparam logic [0:0] S_COLLECT = 1'b0;
    localparam logic [0:0] S_SHIFT   = 1'b1;

    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic [NN-1:0]        r_captured;
    logic [NN-1:0]        w_captured_nxt;
    logic [NN-1:0]        w_merged;
    logic [CW-1:0]        r_idx;
    logic [CW-1:0]        w_idx_nxt;
    logic [dataWidth-1:0] r_buf [NN];
    logic [dataWidth-1:0] r_data_out;
    logic [dataWidth-1:0] w_word;
    logic                 r_data_out_valid;
    logic                 r_overrun;
    logic                 w_emit;
    logic                 w_drop;

    // Next-state, index and capture-mask logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_captured_nxt = r_captured;
        w_merged       = r_captured | in_valid;
        w_emit         = 1'b0;
        w_drop         = 1'b0;
        case (r_state)
            S_COLLECT: begin
                w_drop = |(in_valid & r_captured);
                if (&w_merged) begin
                    w_state_nxt    = S_SHIFT;
                    w_idx_nxt      = '0;
                    w_captured_nxt = '0;
                end else begin
                    w_captured_nxt = w_merged;
                end
            end
            S_SHIFT: begin
                w_drop = |in_valid;
                if (r_idx < CW'(NN)) begin
                    w_emit    = 1'b1;
                    w_idx_nxt = r_idx + CW'(1);
                end else begin
                    w_state_nxt = S_COLLECT;
                end
            end
            default: w_state_nxt = S_COLLECT;
        endcase
    end

    // Read mux selecting the buffered word at the current index.
    always_comb begin
        w_word = '0;
        for (int k = 0; k < NN; k++) begin
            if (r_idx == CW'(k)) begin
                w_word = r_buf[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_COLLECT;
            r_captured       <= '0;
            r_idx            <= '0;
            r_data_out       <= '0;
            r_data_out_valid <= 1'b0;
            r_overrun        <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_captured       <= w_captured_nxt;
            r_idx            <= w_idx_nxt;
            r_data_out_valid <= w_emit;
            if (w_emit) begin
                r_data_out <= w_word;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Buffer contents are don't-care after reset, so no reset branch here.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NN; k++) begin
            if (r_state == S_COLLECT && in_valid[k] && !r_captured[k]) begin
                r_buf[k] <= in_data[k*dataWidth +: dataWidth];
            end
        end
    end

    assign data_out_valid = r_data_out_valid;
    assign data_out       = r_data_out;
    assign busy           = (r_state == S_SHIFT);
    assign overrun        = r_overrun;

`ifdef LAYER_SER_MAXFIND_EN
    logic signed [dataWidth-1:0] r_max_val;
    logic [idxWidth-1:0]         r_max_run_idx;
    logic [idxWidth-1:0]         r_max_idx;
    logic                        r_max_valid;
    logic                        w_max_upd;
    logic                        w_frame_end;

    // Strict greater-than keeps the lower index on ties.
    assign w_max_upd   = w_emit && ((r_idx == '0) || ($signed(w_word) > r_max_val));
    assign w_frame_end = (r_state == S_SHIFT) && !w_emit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_max_val     <= '0;
            r_max_run_idx <= '0;
            r_max_idx     <= '0;
            r_max_valid   <= 1'b0;
        end else begin
            if (w_max_upd) begin
                r_max_val     <= $signed(w_word);
                r_max_run_idx <= idxWidth'(r_idx);
            end
            r_max_valid <= w_frame_end;
            if (w_frame_end) begin
                r_max_idx <= r_max_run_idx;
            end
        end
    end

    assign max_valid = r_max_valid;
    assign max_idx   = r_max_idx;
`endif

endmodule
